lagarto_plic_gateway: RTL
=========================

# lagarto_plic_gateway

Per-source interrupt gateway array for the Lagarto PLIC. Converts raw level- or edge-triggered device requests into one registered pending bit per source. That bit is `source_interrupt_pending_i` of the priority multiplexer tree. Each source is closed once claimed and reopened only on completion.

## Interface
Parameters:
- `NUM_SOURCES`, default 31: number of sources. Source ID k (1..NUM_SOURCES) maps to bit k-1. ID 0 is `NO_INTERRUPT` and is reserved.
- `MAX_PENDING_COUNT`, default 7: saturation value of the per-source edge counter. Minimum 1.

Ports:
- `clk_i` in, 1: single clock for the block.
- `rstn_i` in, 1: reset, asynchronous, active-low.
- `interrupt_source_i` in, NUM_SOURCES: raw device requests, already synchronous to `clk_i`.
- `edge_triggered_i` in, NUM_SOURCES: per-source mode. 1 = rising-edge, 0 = level-high.
- `claim_valid_i` in, 1: claim event strobe, one cycle.
- `claim_id_i` in, MXLEN: ID of the source being claimed.
- `complete_valid_i` in, 1: completion event strobe, one cycle.
- `complete_id_i` in, MXLEN: ID of the source being completed.
- `source_interrupt_pending_o` out, NUM_SOURCES: registered pending bits, fed to the multiplexer tree.
- `in_service_o` out, NUM_SOURCES: registered. 1 = source claimed and awaiting completion.

## Operation
- One independent 3-state FSM per source: IDLE, PENDING, IN_SERVICE.
- `source_interrupt_pending_o[k] = (state==PENDING)`.
- `in_service_o[k] = (state==IN_SERVICE)`.

Per-source request (`req`):
- Level mode: `req = interrupt_source_i[k]`.
- Edge mode: `req = rise | (count != 0)`.
- `rise = interrupt_source_i[k] & ~prev[k]`, where `prev` is the source value registered every cycle.

Transitions:
- IDLE -> PENDING when `req`.
- PENDING -> IN_SERVICE when `claim_valid_i && claim_id_i == k`.
- IN_SERVICE -> PENDING when `complete_valid_i && complete_id_i == k` and `req` is set in that cycle.
- IN_SERVICE -> IDLE on that same completion when `req` is clear.
- All other cases hold state.
- Level mode: a source deasserting while PENDING does NOT clear pending; the pending bit stays set until claimed.

Edge counter (`count`, width `$clog2(MAX_PENDING_COUNT+1)`):
- Each cycle: `count_next = sat(count + rise - fwd)`.
- `fwd` = 1 when the FSM takes a request-consuming transition: IDLE -> PENDING, or IN_SERVICE -> PENDING.
- Saturates at MAX_PENDING_COUNT; extra edges are dropped.
- When `rise` and `fwd` occur together, the net change is 0.
- Forced to 0 while `edge_triggered_i[k] == 0`.

Claim/complete decoding:
- A claim naming a source not in PENDING is ignored.
- A completion naming a source not in IN_SERVICE is ignored.
- ID 0 or ID > NUM_SOURCES is ignored.
- The full MXLEN-bit ID is compared; upper bits must match (zero).
- Claim and completion in the same cycle with different IDs: both take effect.
- Claim and completion in the same cycle with the same ID: the states are mutually exclusive, so at most one applies.

## Timing
- Reset (async assert, sync release): all FSMs IDLE, counters 0, `prev` 0.
- Reset values: `source_interrupt_pending_o` = 0, `in_service_o` = 0.
- A source high (edge mode) on the first cycle after reset counts as a rising edge.
- Request to pending: a source sampled high at edge N drives pending high after edge N (1-cycle registered latency).
- Claim sampled at edge N: pending low and in_service high after edge N.
- Completion sampled at edge N: in_service low after edge N.
  - If `req` is still set, pending is high after the same edge N, with no IDLE bubble.
- Reset asserted mid-service drops all state immediately. Queued edges are lost.
- Changing `edge_triggered_i` mid-operation: the FSM state is kept. The counter clears while in level mode.

## Test plan
- Level, ID 3: raise source 3, hold for 10 cycles.
  - Pending[2] = 1 one cycle later.
  - Claim ID 3: pending = 0, in_service = 1.
  - Complete ID 3 while source is still high: pending = 1 the next cycle.
- Edge, ID 5, MAX_PENDING_COUNT = 7: issue 3 pulses while IN_SERVICE, giving count = 3.
  - Complete ID 5: pending again, count = 2.
  - Two more claim/complete rounds: pending each time, then count = 0, and IDLE after the final completion.
- Saturation: 12 edges on ID 1 while IN_SERVICE -> count = 7.
  - Exactly 7 re-pend cycles follow, then IDLE.
- Illegal accesses, each leaving all outputs unchanged:
  - Claim of ID 0.
  - Claim of ID 32 (NUM_SOURCES = 31).
  - Claim of ID 4 while ID 4 is IDLE.
  - Complete of ID 4 while ID 4 is PENDING.
- Same cycle: claim ID 2 (PENDING) and complete ID 7 (IN_SERVICE) -> ID 2 goes to IN_SERVICE, ID 7 goes to IDLE.
- Reset mid-service: assert `rstn_i` = 0 asynchronously with ID 6 in IN_SERVICE and count = 4.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, ID 6 is pending only if a new edge or level request occurs.

Source files
------------

// File: rtl/lagarto_plic_gateway.sv
// ----------------------------------------------------------------------------
// lagarto_plic_gateway
//
// Per-source interrupt gateway array for the Lagarto PLIC. Each source runs an
// independent IDLE / PENDING / IN_SERVICE state machine that turns a raw
// level- or edge-triggered device request into a single registered pending
// bit for the priority multiplexer tree. A source is closed once claimed and
// reopened only when its completion arrives. In edge mode, rising edges seen
// while the source cannot forward them are queued in a saturating counter.
//
// Ports:
//   clk_i                      - block clock
//   rstn_i                     - asynchronous active-low reset
//   interrupt_source_i  [N]    - raw device requests (synchronous to clk_i)
//   edge_triggered_i    [N]    - per-source mode: 1 = rising edge, 0 = level
//   claim_valid_i / claim_id_i       - one-cycle claim strobe and source ID
//   complete_valid_i / complete_id_i - one-cycle completion strobe and ID
//   source_interrupt_pending_o [N]   - registered pending bits
//   in_service_o               [N]   - registered claimed-awaiting-completion
//
// Source ID k (1..NUM_SOURCES) maps to bit k-1; ID 0 is reserved.
// ----------------------------------------------------------------------------
module lagarto_plic_gateway #(
    parameter int NUM_SOURCES       = 31,
    parameter int MAX_PENDING_COUNT = 7,
    parameter int MXLEN             = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NUM_SOURCES-1:0] interrupt_source_i,
    input  logic [NUM_SOURCES-1:0] edge_triggered_i,
    input  logic                   claim_valid_i,
    input  logic [MXLEN-1:0]       claim_id_i,
    input  logic                   complete_valid_i,
    input  logic [MXLEN-1:0]       complete_id_i,
    output logic [NUM_SOURCES-1:0] source_interrupt_pending_o,
    output logic [NUM_SOURCES-1:0] in_service_o
);

    localparam int CW = $clog2(MAX_PENDING_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PENDING    = 2'b01,
        IN_SERVICE = 2'b10
    } gw_state_e;

    logic [NUM_SOURCES-1:0] prev_q;
    logic [NUM_SOURCES-1:0] rise;

    // Previous source value, registered every cycle regardless of mode so that
    // switching to edge mode sees a consistent history.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= interrupt_source_i;
        end
    end

    assign rise = interrupt_source_i & ~prev_q;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        gw_state_e     state_q;
        gw_state_e     state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [CW+1:0] cnt_sum;
        logic          req;
        logic          fwd;
        logic          claim_hit;
        logic          complete_hit;

        // Full-width ID compare: ID 0 and out-of-range IDs never match any g.
        assign claim_hit    = claim_valid_i    && (claim_id_i    == MXLEN'(g + 1));
        assign complete_hit = complete_valid_i && (complete_id_i == MXLEN'(g + 1));

        assign req = edge_triggered_i[g] ? (rise[g] | (cnt_q != '0))
                                         : interrupt_source_i[g];

        always_comb begin
            state_d = state_q;
            fwd     = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = PENDING;
                        fwd     = 1'b1;
                    end
                end
                PENDING: begin
                    if (claim_hit) begin
                        state_d = IN_SERVICE;
                    end
                end
                IN_SERVICE: begin
                    if (complete_hit) begin
                        if (req) begin
                            // Re-pend directly, no IDLE bubble.
                            state_d = PENDING;
                            fwd     = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Saturating queue of edges: add this cycle's rise, remove the one
        // forwarded; a simultaneous rise and forward leaves the count alone.
        always_comb begin
            cnt_sum = (CW + 2)'(cnt_q) + (CW + 2)'(rise[g]);
            if (fwd && (cnt_sum != '0)) begin
                cnt_sum = cnt_sum - (CW + 2)'(1);
            end
            if (cnt_sum > (CW + 2)'(MAX_PENDING_COUNT)) begin
                cnt_sum = (CW + 2)'(MAX_PENDING_COUNT);
            end
            cnt_d = edge_triggered_i[g] ? cnt_sum[CW-1:0] : '0;
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign source_interrupt_pending_o[g] = (state_q == PENDING);
        assign in_service_o[g]               = (state_q == IN_SERVICE);
    end

endmodule
